// File: rtl/count_seq_chk.sv
// count_seq_chk: tracks an upstream 8-bit incrementing counter.
// The block hunts for LOCK_N consecutive in-sequence samples and then locks.
// While locked it flywheels through up to UNLOCK_N-1 consecutive bad samples.
// It counts mismatches (saturating) and matched 0xFF->0x00 wraps (modulo 256).
module count_seq_chk #(
    parameter int unsigned LOCK_N   = 4,
    parameter int unsigned UNLOCK_N = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_vld,
    input  logic       clr_err,
    output logic       locked,
    output logic       err_pulse,
    output logic [7:0] err_cnt,
    output logic [7:0] wrap_cnt,
    output logic [7:0] expected
);

    localparam logic [3:0] LockN   = 4'(LOCK_N);
    localparam logic [3:0] UnlockN = 4'(UNLOCK_N);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StHunt   = 2'd1,
        StLocked = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] match_run_q, match_run_d;
    logic [3:0] miss_run_q, miss_run_d;
    logic       locked_d;
    logic       err_pulse_d;
    logic [7:0] err_cnt_d;
    logic [7:0] wrap_cnt_d;
    logic [7:0] expected_d;
    logic       is_match;

    assign is_match = (din == expected);

    // Next-state, run counters and registered-output values.
    always_comb begin
        state_d     = state_q;
        match_run_d = match_run_q;
        miss_run_d  = miss_run_q;
        locked_d    = locked;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt;
        wrap_cnt_d  = wrap_cnt;
        expected_d  = expected;

        if (din_vld) begin
            case (state_q)
                StIdle: begin
                    expected_d  = din + 8'd1;
                    match_run_d = 4'd0;
                    state_d     = StHunt;
                end
                StHunt: begin
                    // Always resynchronise to the received value while hunting.
                    expected_d = din + 8'd1;
                    if (is_match) begin
                        if (match_run_q + 4'd1 >= LockN) begin
                            match_run_d = LockN;
                            miss_run_d  = 4'd0;
                            locked_d    = 1'b1;
                            state_d     = StLocked;
                        end else begin
                            match_run_d = match_run_q + 4'd1;
                        end
                    end else begin
                        match_run_d = 4'd0;
                    end
                end
                StLocked: begin
                    if (is_match) begin
                        expected_d = expected + 8'd1;
                        miss_run_d = 4'd0;
                        if (din == 8'h00) begin
                            wrap_cnt_d = wrap_cnt + 8'd1;
                        end
                    end else begin
                        err_pulse_d = 1'b1;
                        err_cnt_d   = (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;
                        if (miss_run_q + 4'd1 >= UnlockN) begin
                            // Too many misses in a row: drop lock and resync to din.
                            miss_run_d  = 4'd0;
                            match_run_d = 4'd0;
                            expected_d  = din + 8'd1;
                            locked_d    = 1'b0;
                            state_d     = StHunt;
                        end else begin
                            miss_run_d = miss_run_q + 4'd1;
                            expected_d = expected + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d  = StIdle;
                    locked_d = 1'b0;
                end
            endcase
        end

        // Clear wins over a coincident increment.
        if (clr_err) begin
            err_cnt_d  = 8'd0;
            wrap_cnt_d = 8'd0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            match_run_q <= 4'd0;
            miss_run_q  <= 4'd0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            err_cnt     <= 8'd0;
            wrap_cnt    <= 8'd0;
            expected    <= 8'd0;
        end else begin
            state_q     <= state_d;
            match_run_q <= match_run_d;
            miss_run_q  <= miss_run_d;
            locked      <= locked_d;
            err_pulse   <= err_pulse_d;
            err_cnt     <= err_cnt_d;
            wrap_cnt    <= wrap_cnt_d;
            expected    <= expected_d;
        end
    end

endmodule

// File: tb/tb_count_seq_chk.sv
// Bench for count_seq_chk: two instances (default thresholds, and LOCK_N=1/UNLOCK_N=15)
// driven with the same stimulus and compared every cycle against a behavioural model.
module tb_count_seq_chk;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_vld;
    logic       clr_err;

    logic       locked_w [2];
    logic       pulse_w  [2];
    logic [7:0] err_w    [2];
    logic [7:0] wrap_w   [2];
    logic [7:0] exp_w    [2];

    int checks = 0;
    int errors = 0;

    // Model state per instance.
    int lock_p   [2] = '{4, 1};
    int unlock_p [2] = '{3, 15};
    int m_mode   [2];  // 0 idle, 1 hunt, 2 locked
    int m_exp    [2];
    int m_mrun   [2];
    int m_xrun   [2];
    int m_err    [2];
    int m_wrap   [2];
    int m_pulse  [2];

    always #5 clk = ~clk;

    count_seq_chk u_dut0 (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_vld   (din_vld),
        .clr_err   (clr_err),
        .locked    (locked_w[0]),
        .err_pulse (pulse_w[0]),
        .err_cnt   (err_w[0]),
        .wrap_cnt  (wrap_w[0]),
        .expected  (exp_w[0])
    );

    count_seq_chk #(
        .LOCK_N   (1),
        .UNLOCK_N (15)
    ) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_vld   (din_vld),
        .clr_err   (clr_err),
        .locked    (locked_w[1]),
        .err_pulse (pulse_w[1]),
        .err_cnt   (err_w[1]),
        .wrap_cnt  (wrap_w[1]),
        .expected  (exp_w[1])
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step(input int i, input bit rst, input bit vld, input int d,
                              input bit clr);
        if (rst) begin
            m_mode[i] = 0; m_exp[i] = 0; m_mrun[i] = 0; m_xrun[i] = 0;
            m_err[i] = 0; m_wrap[i] = 0; m_pulse[i] = 0;
            return;
        end
        m_pulse[i] = 0;
        if (vld) begin
            if (m_mode[i] == 0) begin
                m_exp[i] = (d + 1) % 256; m_mrun[i] = 0; m_mode[i] = 1;
            end else if (m_mode[i] == 1) begin
                if (d == m_exp[i]) begin
                    m_mrun[i]++;
                    if (m_mrun[i] == lock_p[i]) begin
                        m_mode[i] = 2; m_xrun[i] = 0;
                    end
                end else begin
                    m_mrun[i] = 0;
                end
                m_exp[i] = (d + 1) % 256;
            end else begin
                if (d == m_exp[i]) begin
                    m_exp[i] = (m_exp[i] + 1) % 256;
                    m_xrun[i] = 0;
                    if (d == 0) m_wrap[i] = (m_wrap[i] + 1) % 256;
                end else begin
                    m_pulse[i] = 1;
                    if (m_err[i] < 255) m_err[i]++;
                    m_xrun[i]++;
                    if (m_xrun[i] == unlock_p[i]) begin
                        m_mode[i] = 1; m_exp[i] = (d + 1) % 256; m_mrun[i] = 0;
                    end else begin
                        m_exp[i] = (m_exp[i] + 1) % 256;
                    end
                end
            end
        end
        if (clr) begin
            m_err[i] = 0; m_wrap[i] = 0;
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs of both instances.
    task automatic cyc(input bit rst, input bit vld, input int d, input bit clr);
        reset = rst; din_vld = vld; din = 8'(d); clr_err = clr;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, rst, vld, d % 256, clr);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("locked%0d", i), int'(locked_w[i]), int'(m_mode[i] == 2));
            check($sformatf("err_pulse%0d", i), int'(pulse_w[i]), m_pulse[i]);
            check($sformatf("err_cnt%0d", i), int'(err_w[i]), m_err[i]);
            check($sformatf("wrap_cnt%0d", i), int'(wrap_w[i]), m_wrap[i]);
            check($sformatf("expected%0d", i), int'(exp_w[i]), m_exp[i]);
        end
    endtask

    task automatic run_seq(input int from, input int n);
        for (int k = 0; k < n; k++) cyc(0, 1, (from + k) % 256, 0);
    endtask

    initial begin
        reset = 1'b1; din_vld = 1'b0; din = 8'd0; clr_err = 1'b0;
        for (int i = 0; i < 2; i++) model_step(i, 1, 0, 0, 0);

        // Reset state, with vld and clr also asserted.
        cyc(1, 1, 8'h33, 1);
        cyc(1, 0, 0, 0);
        check("rst_locked", int'(locked_w[0]), 0);
        check("rst_expected", int'(exp_w[0]), 0);

        // Lock acquisition.
        run_seq(0, 5);
        check("acq_locked", int'(locked_w[0]), 1);
        check("acq_expected", int'(exp_w[0]), 5);
        check("acq_err", int'(err_w[0]), 0);

        // Wrap while locked.
        cyc(1, 0, 0, 0);
        run_seq(8'hF8, 10);
        check("wrap_cnt", int'(wrap_w[0]), 1);
        check("wrap_expected", int'(exp_w[0]), 2);
        check("wrap_locked", int'(locked_w[0]), 1);

        // Single glitch with flywheel.
        run_seq(2, 14);
        cyc(0, 1, 8'h10, 0);
        cyc(0, 1, 8'h55, 0);
        check("glitch_pulse", int'(pulse_w[0]), 1);
        cyc(0, 1, 8'h12, 0);
        check("glitch_err", int'(err_w[0]), 1);
        check("glitch_locked", int'(locked_w[0]), 1);
        check("glitch_expected", int'(exp_w[0]), 8'h13);

        // Loss of lock and relock.
        run_seq(8'h13, 13);
        cyc(0, 0, 0, 1);
        check("clr_idle", int'(err_w[0]), 0);
        run_seq(8'h80, 3);
        check("loss_err", int'(err_w[0]), 3);
        check("loss_locked", int'(locked_w[0]), 0);
        check("loss_expected", int'(exp_w[0]), 8'h83);
        run_seq(8'h83, 4);
        check("relock_locked", int'(locked_w[0]), 1);
        check("relock_expected", int'(exp_w[0]), 8'h87);

        // din_vld gaps.
        for (int k = 0; k < 5; k++) cyc(0, 0, $urandom_range(0, 255), 0);
        check("gap_expected", int'(exp_w[0]), 8'h87);
        cyc(0, 1, 8'h87, 0);
        check("gap_match_locked", int'(locked_w[0]), 1);

        // Reset while locked.
        cyc(1, 1, 8'h88, 0);
        check("midrst_locked", int'(locked_w[0]), 0);
        check("midrst_expected", int'(exp_w[0]), 0);
        check("midrst_wrap", int'(wrap_w[0]), 0);

        // Saturation on the UNLOCK_N=15 instance, then clear coinciding with a mismatch.
        for (int b = 0; b < 25; b++) begin
            run_seq(b * 16, 5);
            for (int k = 0; k < 14; k++) cyc(0, 1, m_exp[1] ^ 8'h5A, 0);
        end
        check("sat_err", int'(err_w[1]), 255);
        run_seq(8'h40, 2);
        cyc(0, 1, m_exp[1] ^ 8'h5A, 1);
        check("clr_pulse", int'(pulse_w[1]), 1);
        check("clr_err", int'(err_w[1]), 0);

        // Randomised phase.
        for (int n = 0; n < 3000; n++) begin
            int d;
            bit rst, vld, clr;
            rst = ($urandom_range(0, 199) == 0);
            vld = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 5) == 0) d = $urandom_range(0, 255);
            else d = m_exp[$urandom_range(0, 1)];
            cyc(rst, vld, d, clr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
